// File: rtl/outerprodrc_unary_enc_pkg.sv
// outerprodrc_unary_enc_pkg: shared widths, coding selectors, FSM states and stream-length helper
package outerprodrc_unary_enc_pkg;
  localparam int DEF_BITWIDTH = 8;
  localparam int CODING_TEMPORAL = 0;
  localparam int CODING_RATE = 1;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int stream_len(input int bw);
    return 1 << (bw - 1);
  endfunction
endpackage

// File: rtl/outerprodrc_unary_enc_bit.sv
// outerprodrc_unary_enc_bit: per-element operand register, magnitude compare and sign/bit registers
module outerprodrc_unary_enc_bit
  import outerprodrc_unary_enc_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic                fire,
  input  logic [BITWIDTH-1:0] data,
  input  logic [BITWIDTH-2:0] code,
  output logic                sign,
  output logic                ubit
);
  logic [BITWIDTH-1:0] op;
  // operand is captured only on a handshake accept
  always_ff @(posedge clk) begin
    if (rst) op <= '0;
    else if (load) op <= data;
  end
  // each fired cycle emits one unary bit; the old operand still drives the last bit when a new vector loads
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sign <= 1'b0;
      ubit <= 1'b0;
    end else if (fire) begin
      sign <= op[BITWIDTH-1];
      ubit <= code < op[BITWIDTH-2:0];
    end
  end
endmodule

// File: rtl/outerprodrc_unary_enc.sv
// outerprodrc_unary_enc: binary sign-magnitude vector to per-element unary bitstream encoder
module outerprodrc_unary_enc
  import outerprodrc_unary_enc_pkg::*;
#(
  parameter int VECLEN   = 4,
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int CODING   = CODING_TEMPORAL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       vec_valid,
  output logic                       vec_ready,
  input  logic [VECLEN*BITWIDTH-1:0] vec_data,
  output logic                       valid,
  output logic                       last,
  output logic [VECLEN-1:0]          sign,
  output logic [VECLEN-1:0]          bits
);
  localparam int MW = BITWIDTH - 1;
  localparam int L = stream_len(BITWIDTH);
  state_t state;
  logic [MW-1:0] cnt, code;
  logic at_last, fire, accept;
  // handshake: ready in idle, or on the enabled last bit so streams run back-to-back
  always_comb begin
    at_last = cnt == MW'(L - 1);
    fire = (state == RUN) && en && !clr;
    vec_ready = !clr && ((state == IDLE) || (fire && at_last));
    accept = vec_valid && vec_ready;
  end
  // rate coding walks the counter bit-reversed so ones spread evenly over the stream
  always_comb begin
    code = cnt;
    for (int k = 0; k < MW; k++) code[k] = (CODING == CODING_RATE) ? cnt[MW-1-k] : cnt[k];
  end
  // FSM with the shared stream counter and registered valid/last
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else begin
      valid <= fire;
      last  <= fire && at_last;
      if (accept) begin
        state <= RUN;
        cnt   <= '0;
      end else if (fire) begin
        cnt <= cnt + 1'b1;
        if (at_last) state <= IDLE;
      end
    end
  end
  for (genvar g = 0; g < VECLEN; g++) begin : g_el
    outerprodrc_unary_enc_bit #(.BITWIDTH(BITWIDTH)) u_bit (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .load (accept),
      .fire (fire),
      .data (vec_data[g*BITWIDTH +: BITWIDTH]),
      .code (code),
      .sign (sign[g]),
      .ubit (bits[g])
    );
  end
endmodule
